// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StPulse    = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFault    = 3'd4
  } seq_state_e;

  localparam int unsigned LOL_MAX = 255;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous status bit.
module sync_bit #(
  parameter int unsigned Depth = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [Depth-1:0] stages_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages_q <= '0;
    end else begin
      stages_q <= {stages_q[Depth-2:0], d};
    end
  end

  assign q = stages_q[Depth-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset/lock acquisition with timeout, bounded retries and a stability window
// before releasing the datapath reset; re-sequences on loss of lock or on request.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned MAX_RETRIES      = 4,
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned CNT_W            = 17
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [7:0] retry_cnt,
  output logic [7:0] lol_cnt
);

  localparam logic [CNT_W-1:0] PulseLast   = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [7:0]       RetryLimit  = 8'(MAX_RETRIES);
  localparam logic [7:0]       LolSat      = 8'(LOL_MAX);

  logic lock_s;

  sync_bit #(
    .Depth(SYNC_STAGES)
  ) u_lock_sync (
    .clk(refclk),
    .rst(rst),
    .d  (pll_locked),
    .q  (lock_s)
  );

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       retry_q, retry_d;
  logic [7:0]       lol_q, lol_d;
  logic             pll_rst_q, sys_rst_q, ready_q, fault_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    lol_d   = lol_q;
    unique case (state_q)
      StPulse: begin
        if (timer_q == PulseLast) state_d = StWaitLock;
        else                      timer_d = timer_q + CNT_W'(1);
      end
      StWaitLock: begin
        // Lock takes priority over a coincident timeout.
        if (lock_s) begin
          state_d = StStable;
        end else if (timer_q == TimeoutLast) begin
          retry_d = retry_q + 8'd1;
          state_d = (retry_d == RetryLimit) ? StFault : StPulse;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      StStable: begin
        if (!lock_s) begin
          state_d = StWaitLock;
        end else if (timer_q == StableLast) begin
          state_d = StRun;
          retry_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      StRun: begin
        if (!lock_s) begin
          if (lol_q != LolSat) lol_d = lol_q + 8'd1;
          state_d = StPulse;
        end else if (relock_req) begin
          state_d = StPulse;
        end
      end
      StFault: begin
        if (relock_req) begin
          retry_d = '0;
          state_d = StPulse;
        end
      end
      default: state_d = StPulse;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  // Outputs decode the next state so they switch on the same edge as the state register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= StPulse;
      timer_q   <= '0;
      retry_q   <= '0;
      lol_q     <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      lol_q     <= lol_d;
      pll_rst_q <= (state_d == StPulse) || (state_d == StFault);
      sys_rst_q <= (state_d != StRun);
      ready_q   <= (state_d == StRun);
      fault_q   <= (state_d == StFault);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign lol_cnt   = lol_q;

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controller for the PLL instance that generates the OFDM datapath clock.
- After power-up or reset, pulses the PLL reset and waits for lock with a timeout and bounded retries.
- Requires lock to stay stable for a fixed time before releasing the downstream system reset.
- Runs in the free-running reference clock domain; monitors lock continuously and re-sequences the PLL on loss of lock or on request.

Parameters:
- RST_PULSE_CYC, 16: refclk cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT_CYC, 65536: max cycles in WAIT_LOCK before an attempt counts as failed (>=2).
- LOCK_STABLE_CYC, 1024: consecutive synchronized-lock cycles required before release (>=1).
- MAX_RETRIES, 4: failed attempts allowed before FAULT (1..255).
- SYNC_STAGES, 2: synchronizer depth for pll_locked (>=2).
- CNT_W, 17: timer width; must satisfy 2^CNT_W > max(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC).

Ports:
- refclk, input, 1: reference clock; all logic here is on this clock.
- rst, input, 1: synchronous, active-high reset.
- pll_locked, input, 1: PLL locked flag, asynchronous to refclk.
- relock_req, input, 1: single-cycle request to force a PLL re-sequence.
- pll_rst, output, 1: drives the PLL reset input.
- sys_rst, output, 1: active-high reset for the datapath.
- ready, output, 1: high only in RUN.
- fault, output, 1: high only in FAULT.
- retry_cnt, output, 8: failed attempts since the last entry to RUN.
- lol_cnt, output, 8: loss-of-lock events since rst; saturates at 255.

Behaviour:
- pll_locked passes through SYNC_STAGES flops (all reset to 0); the last stage is lock_s. All decisions use lock_s only.
- All outputs are registered and change in the same cycle the state register enters a new state.
- Reset values while rst=1:
  - state = PULSE; timer = 0.
  - pll_rst = 1, sys_rst = 1.
  - ready = 0, fault = 0.
  - retry_cnt = 0, lol_cnt = 0.
- State PULSE:
  - pll_rst = 1, sys_rst = 1.
  - timer counts 0..RST_PULSE_CYC-1, then goes to WAIT_LOCK with timer cleared.
  - pll_rst is therefore high exactly RST_PULSE_CYC cycles.
- State WAIT_LOCK:
  - pll_rst = 0, sys_rst = 1.
  - If lock_s=1: go to STABLE, timer cleared.
  - Else if timer reaches LOCK_TIMEOUT_CYC-1: retry_cnt increments.
    - If the new value equals MAX_RETRIES, go to FAULT.
    - Otherwise go to PULSE.
  - If lock_s rises in the timeout cycle, lock wins.
- State STABLE:
  - pll_rst = 0, sys_rst = 1.
  - If lock_s=0: go back to WAIT_LOCK with the timer cleared. This is a fresh timeout window and retry_cnt is unchanged.
  - After LOCK_STABLE_CYC consecutive lock_s=1 cycles: go to RUN and clear retry_cnt.
- State RUN:
  - sys_rst = 0, ready = 1.
  - If lock_s=0: lol_cnt increments (saturating) and the block goes to PULSE. sys_rst=1 and ready=0 take effect on the next edge.
  - Else if relock_req=1: go to PULSE without changing lol_cnt.
  - When both occur in the same cycle, it counts as loss of lock.
- State FAULT:
  - pll_rst = 1, sys_rst = 1, fault = 1.
  - retry_cnt holds MAX_RETRIES.
  - Exits only on relock_req, which clears retry_cnt and fault and goes to PULSE, or on rst.
- relock_req is ignored in PULSE, WAIT_LOCK and STABLE.
- rst mid-sequence, including in RUN, aborts immediately to the reset values. The synchronizer is cleared as well.
- The timer never wraps. It is cleared on every state change.
- Glitch rules:
  - sys_rst is never low unless the state register is RUN.
  - pll_rst is never low while in PULSE or FAULT.

Decomposition:
- Package pll_seq_pkg:
  - state enum PULSE/WAIT_LOCK/STABLE/RUN/FAULT, 3-bit encoding.
  - constant LOL_MAX = 255.
- Sub-module sync_bit, parameterized by depth, for the pll_locked synchronizer. It is reusable for other asynchronous status inputs.
- Everything else stays in one FSM-plus-counters module.

Test Plan:
All scenarios use RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=100, LOCK_STABLE_CYC=20, MAX_RETRIES=2, SYNC_STAGES=2.
- Clean lock: release rst, raise pll_locked 10 cycles after pll_rst falls.
  - pll_rst high exactly 4 cycles.
  - ready and sys_rst=0 arrive 2+20 cycles after pll_locked rises, plus one state-entry edge.
  - retry_cnt=0.
- Timeout then success: hold pll_locked=0 for the first attempt, then lock on the second.
  - retry_cnt=1 after 100 WAIT_LOCK cycles.
  - A second 4-cycle pll_rst pulse follows.
  - After the block reaches RUN, retry_cnt=0.
- Exhaustion: pll_locked stuck low.
  - Two timeouts, then fault=1, retry_cnt=2, pll_rst=1.
  - Block stays in FAULT for 1000 cycles.
  - A relock_req pulse leads to PULSE with fault=0.
- Lock glitch in STABLE: drop pll_locked for 3 cycles at stable count 15.
  - Block returns to WAIT_LOCK and ready stays 0.
  - Block reaches RUN only after a full 20 stable cycles.
- Loss of lock in RUN: drop pll_locked.
  - 2 cycles later the state leaves RUN: sys_rst=1, ready=0, lol_cnt=1, a new 4-cycle pll_rst pulse.
  - With relock_req and lock loss in the same cycle, lol_cnt still increments.
- Saturation and reset: force 256 loss-of-lock events, giving lol_cnt=255. Then assert rst in RUN.
  - Next cycle: lol_cnt=0, pll_rst=1, sys_rst=1, ready=0.
